sistema_seq: RTL
================

# sistema_seq

Parametrised sequential arithmetic unit and successor to the combinational 4-bit `sistema` adder. It adds or multiplies two N-bit unsigned operands under a start/done handshake: addition takes one cycle, multiplication uses an N-cycle shift-add datapath. It sits beside the combinational unit in the datapath, with the result held until the next operation completes. It serves wider operand widths without growing a full array multiplier.

## Interface
- `N`, default 4: operand width, N ≥ 2; result width is 2N.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  request; sampled only when `busy`=0
- `mode`  in  1  0 = add, 1 = multiply; sampled with `start`
- `b`  in  N  operand B, unsigned; sampled with `start`
- `c`  in  N  operand C, unsigned; sampled with `start`
- `s`  out  2N  result, registered, held between operations
- `cout`  out  1  carry flag, registered
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: `s` and `cout` updated this cycle

## Operation
- States: IDLE, ADD, MUL.
- IDLE: `start`=1 latches `b`, `c` and `mode`. The state moves to ADD (mode 0) or to MUL (mode 1), with the MUL step counter set to 0 and the partial product set to 0.
- ADD, one cycle:
  - s[N:0] = b+c and s[2N-1:N+1] = 0.
  - cout = s[N].
  - `done`=1, then return to IDLE.
- MUL, N cycles: at step i, if bit i of the latched C is 1, add (B << i) to the 2N-bit partial product.
  - After step N-1: s = B*C and cout = 0 (the product always fits in 2N bits).
  - `done`=1, then return to IDLE.
- `start` while `busy`=1 is ignored. Operands may change freely while busy.
- `s` and `cout` change only on a `done` cycle or on reset. Intermediate partial products are never visible on `s`.
- Reset (`rst_n`=0 at a rising edge), including during an operation: state IDLE, s=0, cout=0, busy=0, done=0. An aborted operation never raises `done`.

## Timing
- Reset values of all outputs: 0.
- In the timeline below, t0 is the edge at which IDLE samples `start`=1.
- `busy`=1 from after t0 until the result edge.
- Add: result and `done` appear after edge t0+1, so latency is 1 cycle.
- Multiply: result and `done` appear after edge t0+N, so latency is N cycles.
- On the `done` cycle the block is already in IDLE with `busy`=0.
  - A `start` present in that cycle is accepted at the next edge.
  - Back-to-back issue therefore gives one operation every 2 cycles for add and every N+1 cycles for multiply.
- `done` is high for exactly one cycle per accepted operation.

## Configuration
- Macro: `SISTEMA_SEQ_ACC_EN`.
- Defined (multiply-accumulate):
  - Multiply mode produces s = (s_prev + B*C) mod 2^(2N).
  - cout = carry out of that 2N-bit addition.
  - The accumulation happens on the final MUL step. No extra cycle is added.
  - Add mode and reset both overwrite `s`, which clears the accumulator.
- Undefined: multiply mode produces s = B*C with cout = 0. No accumulate logic is synthesised.

## Test plan (N=4)
- Reset, then add B=5, C=6: s=11, cout=0, `done` one cycle after t0, `busy`=1 for exactly 1 cycle.
- Add B=15, C=1, then add B=1, C=1 issued during the first `done` cycle: first result s=16 with cout=1, second result s=2 with cout=0, 2 cycles apart.
- Multiply B=15, C=15: s=225, cout=0, `done` 4 cycles after t0. Pulsing `start` at t0+2 with B=1, C=1 has no effect, and `s` holds 225 afterwards.
- Multiply B=2, C=1, then assert `rst_n`=0 at t0+2: no `done` pulse, s=0, busy=0; a following add B=1, C=1 gives s=2.
- `SISTEMA_SEQ_ACC_EN` defined:
  - Multiply 5×6 then 2×3: s=30 then s=36.
  - After reset, multiply 15×15 twice: s=225 then s=194 with cout=1.
  - Then add B=1, C=1: s=2, cout=0.

Source files
------------

// File: rtl/sistema_seq_if.sv
// sistema_seq_if -- request/result bundle for the sequential add/multiply unit.
//   master: drives start, mode, b, c; observes s, cout, busy, done
//   slave : the arithmetic unit itself
// Parameter N: operand width (result is 2N bits).
interface sistema_seq_if #(parameter int N = 4);
    logic           start;
    logic           mode;   // 0 = add, 1 = multiply
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic [2*N-1:0] s;
    logic           cout;
    logic           busy;
    logic           done;

    modport master (output start, mode, b, c, input  s, cout, busy, done);
    modport slave  (input  start, mode, b, c, output s, cout, busy, done);
endinterface

// File: rtl/sistema_seq.sv
// sistema_seq -- sequential unsigned add / shift-add multiply, start/done handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : sistema_seq_if slave (start/mode/b/c in; s/cout/busy/done out)
// Add completes one cycle after acceptance, multiply N cycles after.
// Result s/cout is registered and held until the next completion.
// Optional macro SISTEMA_SEQ_ACC_EN: multiply accumulates into s
// (s = s_prev + B*C mod 2^2N, cout = carry of that sum).
module sistema_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sistema_seq_if.slave bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ADD, MUL} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   b_q, b_d, c_q, c_d;
    logic [SW-1:0]  step_q, step_d;
    logic [2*N-1:0] pp_q, pp_d;
    logic [2*N-1:0] s_q, s_d;
    logic           cout_q, cout_d;
    logic           done_q, done_d;

    logic [N:0]     sum;
    logic [2*N-1:0] addend, pp_nxt;
`ifdef SISTEMA_SEQ_ACC_EN
    logic [2*N:0]   acc_sum;
`endif

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        c_d     = c_q;
        step_d  = step_q;
        pp_d    = pp_q;
        s_d     = s_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        sum    = {1'b0, b_q} + {1'b0, c_q};
        // One shift-add step; the final step's sum goes straight to s so the
        // product lands without an extra cycle.
        addend = c_q[step_q] ? ({{N{1'b0}}, b_q} << step_q) : '0;
        pp_nxt = pp_q + addend;
`ifdef SISTEMA_SEQ_ACC_EN
        acc_sum = {1'b0, s_q} + {1'b0, pp_nxt};
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    b_d     = bus.b;
                    c_d     = bus.c;
                    step_d  = '0;
                    pp_d    = '0;
                    state_d = bus.mode ? MUL : ADD;
                end
            end
            ADD: begin
                s_d     = {{(N-1){1'b0}}, sum};
                cout_d  = sum[N];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            MUL: begin
                if (step_q == SW'(N-1)) begin
`ifdef SISTEMA_SEQ_ACC_EN
                    s_d    = acc_sum[2*N-1:0];
                    cout_d = acc_sum[2*N];
`else
                    s_d    = pp_nxt;
                    cout_d = 1'b0;
`endif
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    step_d = step_q + SW'(1);
                    pp_d   = pp_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            c_q     <= '0;
            step_q  <= '0;
            pp_q    <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            c_q     <= c_d;
            step_q  <= step_d;
            pp_q    <= pp_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);
endmodule
